// File: rtl/rv32_ifetch_v2.sv
// rv32_ifetch_v2: instruction fetch with one outstanding memory read and a small
// instruction buffer feeding decode; flush discards buffered and in-flight words.
module rv32_ifetch_v2 #(
   parameter int          DEPTH = 2,
   parameter logic [31:0] NOP   = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_in,
   input  logic        fetch_en,
   input  logic        flush,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        busy,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_valid
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
   state_t state, state_nx;
   logic [31:0]   req_pc;
   logic [31:0]   buf_pc [DEPTH];
   logic [31:0]   buf_in [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          hs, outst, credit, go, push, pop;
   assign imem_req    = state == REQ;
   assign imem_addr   = imem_req ? {pc_in[31:2], 2'b00} : '0;
   assign hs          = imem_req & imem_ready;
   assign busy        = ~hs;
   assign outst       = (state == WAIT) | (state == DRAIN);
   // counting the outstanding read as occupied guarantees its push always fits
   assign credit      = (int'(count) + int'(outst)) < DEPTH;
   assign go          = fetch_en & (flush | credit);
   assign push        = (state == WAIT) & imem_rvalid & ~flush;
   assign instr_valid = count != '0;
   assign pop         = instr_valid & ~stall & ~flush;
   assign instr_out   = instr_valid ? buf_in[rd_ptr] : NOP;
   assign instr_pc    = instr_valid ? buf_pc[rd_ptr] : '0;
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = (fetch_en & credit & ~flush) ? REQ : IDLE;
         REQ:     state_nx = hs ? (flush ? DRAIN : WAIT) : (flush ? IDLE : REQ);
         WAIT:    state_nx = imem_rvalid ? (go ? REQ : IDLE) : (flush ? DRAIN : WAIT);
         DRAIN:   state_nx = imem_rvalid ? (go ? REQ : IDLE) : DRAIN;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         req_pc <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         state <= state_nx;
         if (hs) req_pc <= {pc_in[31:2], 2'b00};
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc[wr_ptr] <= req_pc;
         buf_in[wr_ptr] <= imem_rdata;
      end
   end
endmodule

// File: doc/rv32_ifetch_v2.md
Name: rv32_ifetch_v2

Overview:
Instruction-fetch stage directly downstream of the PC unit.
- Takes the current fetch PC and issues word reads to instruction memory over a request/ready + rvalid handshake with variable latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode.
- Drives `busy` back to the PC unit so the PC advances only when a fetch is accepted.
- Discards in-flight and buffered instructions on a branch flush.

Parameters:
- DEPTH, 2, instruction buffer entries; power of 2, ≥2.
- NOP, 32'h0000_0013, instruction driven on instr_out when no valid instruction (addi x0,x0,0).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- pc_in  in  32  fetch address from PC unit (pc_out)
- fetch_en  in  1  PC unit enabled (~halt); no new requests when 0
- flush  in  1  branch redirect; kill buffered and in-flight fetches
- stall  in  1  decode cannot accept an instruction this cycle
- imem_req  out  1  memory read request
- imem_addr  out  32  request address, word aligned ({pc_in[31:2],2'b00})
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- busy  out  1  to PC unit; 0 only in the cycle a request is accepted
- instr_out  out  32  instruction to decode (code_bus)
- instr_pc  out  32  PC of instr_out (execute_pc)
- instr_valid  out  1  instr_out/instr_pc valid

Behaviour:
- **Reset values:** imem_req=0, imem_addr=0, busy=1, instr_out=NOP, instr_pc=0, instr_valid=0, FIFO empty, FSM=IDLE. Reset asserted mid-transaction clears everything immediately; any rvalid pending at reset is dropped.
- **FSM states:** IDLE, REQ, WAIT, DRAIN.
  - IDLE→REQ when fetch_en & credit.
  - REQ: imem_req=1, imem_addr=pc_in. Handshake = imem_req & imem_ready; on handshake, latch pc_in into req_pc and go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid, push {req_pc, imem_rdata}, then go to REQ if fetch_en & credit, else IDLE.
  - DRAIN: wait for the single outstanding rvalid, discard it, then go to REQ/IDLE as from WAIT.
- **Outstanding requests:** at most 1.
- **credit:** (FIFO count + outstanding) < DEPTH, so a push can never overflow.
- **busy:** = ~(imem_req & imem_ready) (combinational). The PC increments exactly once per accepted request; pc_in must be stable while imem_req=1.
- **Response timing:** rvalid arrives ≥1 cycle after handshake. rvalid in the handshake cycle, or when nothing is outstanding, is ignored.
- **Output:** instr_out/instr_pc/instr_valid are the FIFO head, registered (no combinational path from imem_rdata). instr_out=NOP and instr_pc=0 when empty. Pop when instr_valid & ~stall. Push and pop in the same cycle leaves count unchanged. On full & stall, no new request is issued.
- **Flush** (highest priority):
  - Next cycle FIFO is empty, instr_valid=0.
  - A same-cycle push or pop is ignored.
  - If a request is outstanding (WAIT, or handshake this cycle), go to DRAIN. If the rvalid arrives in the flush cycle itself, discard it and go to IDLE/REQ.
  - If in REQ without handshake, drop imem_req for one cycle; the next request uses the redirected pc_in.
- **fetch_en=0:** no new request. An outstanding response still completes and is buffered. The FIFO still drains to decode.
- **Address:** pc_in[1:0] ignored; wrap at 32'hFFFF_FFFC is the PC unit's concern.

Test Plan:
- **Reset:** rst_n low mid-WAIT with rvalid pending → imem_req=0, instr_valid=0, instr_out=32'h13, busy=1; rvalid arriving after release is ignored.
- **Streaming:** imem_ready=1, 1-cycle latency, pc 0,4,8 with rdata A0,A1,A2 → decode sees (0,A0),(4,A1),(8,A2) in order; busy low once per request.
- **Backpressure:** stall=1 for 6 cycles → FIFO fills to 2, imem_req stays 0, busy=1. Release → entries pop in order, then fetching resumes at the next PC.
- **Flush with outstanding request:** request to 0x10 outstanding, flush with pc_in=0x40 → 0x10 data discarded in DRAIN, next imem_addr=0x40, next instr_pc=0x40.
- **Flush with FIFO full plus rvalid:** flush and rvalid in the same cycle with FIFO full → instr_valid=0 next cycle, count=0, discarded data never appears.
- **Variable latency and halt:** imem_ready low 3 cycles, then latency 4, with fetch_en dropped during WAIT → exactly one instruction is buffered, no further imem_req, busy=1.
